// File: rtl/rr_arbiter_16.sv
// Registered 16-way round-robin arbiter with hold control (done, request drop, MAX_HOLD timeout).
// Grant is one-hot or zero and feeds the 16-to-4 encoder directly; grant_idx carries the same index in binary.
module rr_arbiter_16 #(
   parameter int N        = 16,
   parameter int IDX_W    = 4,
   parameter int MAX_HOLD = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     req,
   input  logic             done,
   output logic [N-1:0]     grant,
   output logic             grant_valid,
   output logic [IDX_W-1:0] grant_idx,
   output logic             timeout
);

   localparam int CNT_W = 8;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      GRANTED = 1'b1
   } state_t;

   state_t             state_r, state_s;
   logic [IDX_W-1:0]   ptr_r, ptr_s;
   logic [CNT_W-1:0]   hold_cnt_r, hold_cnt_s;
   logic [N-1:0]       grant_r, grant_s;
   logic [IDX_W-1:0]   idx_r, idx_s;
   logic               valid_r, valid_s;
   logic               timeout_r, timeout_s;
   logic [IDX_W-1:0]   pick_s;
   logic               user_rel_s;
   logic               hold_hit_s;

   // First set request bit at or above p, wrapping naturally through the 4-bit index.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [N-1:0] r, input logic [IDX_W-1:0] p);
      logic [IDX_W-1:0] cand;
      logic             found;
      rr_pick = p;
      found   = 1'b0;
      for (int i = 0; i < N; i++) begin
         cand = p + i[IDX_W-1:0];
         if (!found && r[cand]) begin
            rr_pick = cand;
            found   = 1'b1;
         end
      end
   endfunction

   // Arbitration candidate and release causes for the current grantee.
   always_comb begin
      pick_s     = rr_pick(req, ptr_r);
      user_rel_s = done | ~req[idx_r];
      hold_hit_s = (hold_cnt_r == CNT_W'(MAX_HOLD));
   end

   // Next-state and next-output logic of the IDLE/GRANTED machine.
   always_comb begin
      state_s    = state_r;
      ptr_s      = ptr_r;
      hold_cnt_s = hold_cnt_r;
      grant_s    = grant_r;
      idx_s      = idx_r;
      valid_s    = valid_r;
      timeout_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (|req) begin
               state_s    = GRANTED;
               grant_s    = {{(N-1){1'b0}}, 1'b1} << pick_s;
               idx_s      = pick_s;
               valid_s    = 1'b1;
               hold_cnt_s = {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
               grant_s = {N{1'b0}};
               valid_s = 1'b0;
            end
         end
         GRANTED: begin
            if (user_rel_s || hold_hit_s) begin
               // Release always leaves one idle cycle; timeout only when the hold limit alone fired.
               state_s   = IDLE;
               grant_s   = {N{1'b0}};
               valid_s   = 1'b0;
               ptr_s     = idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
               timeout_s = hold_hit_s & ~user_rel_s;
            end else if (hold_cnt_r != {CNT_W{1'b1}}) begin
               hold_cnt_s = hold_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
               hold_cnt_s = hold_cnt_r;
            end
         end
         default: begin
            state_s = IDLE;
            grant_s = {N{1'b0}};
            valid_s = 1'b0;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         ptr_r      <= {IDX_W{1'b0}};
         hold_cnt_r <= {CNT_W{1'b0}};
         grant_r    <= {N{1'b0}};
         idx_r      <= {IDX_W{1'b0}};
         valid_r    <= 1'b0;
         timeout_r  <= 1'b0;
      end else begin
         state_r    <= state_s;
         ptr_r      <= ptr_s;
         hold_cnt_r <= hold_cnt_s;
         grant_r    <= grant_s;
         idx_r      <= idx_s;
         valid_r    <= valid_s;
         timeout_r  <= timeout_s;
      end
   end

   assign grant       = grant_r;
   assign grant_valid = valid_r;
   assign grant_idx   = idx_r;
   assign timeout     = timeout_r;

endmodule
